// File: rtl/prio_encoder_rr_pkg.sv
// Shared definitions for the parametrised priority encoder family.
//   mode_e : grant selection mode carried on the mode port
//   clog2  : index width for a given request count (minimum 1 bit)
package prio_enc_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  function automatic int unsigned clog2(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/prio_encoder_rr_if.sv
// Request / grant bundle for prio_encoder_rr.
//   en, mode, req, out_ready            : driven by the master (requester side)
//   out_valid, out_idx, out_multi, busy : driven by the slave (encoder)
interface prio_encoder_rr_if #(
  parameter int unsigned N = 16
);
  import prio_enc_pkg::*;

  localparam int unsigned W = clog2(N);

  logic         en;
  logic         mode;
  logic [N-1:0] req;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic         out_multi;
  logic         busy;

  modport master (
    output en, mode, req, out_ready,
    input  out_valid, out_idx, out_multi, busy
  );

  modport slave (
    input  en, mode, req, out_ready,
    output out_valid, out_idx, out_multi, busy
  );

endinterface

// File: rtl/prio_encoder_rr_rr_find.sv
// Combinational grant search.
//   req   : request vector
//   lp    : last-grant pointer (round-robin start is lp+1)
//   mode  : MODE_FIXED = highest set index, MODE_RR = rotating search
//   grant : selected index (meaningless when any=0)
//   any   : at least one request set
//   multi : more than one request set
module rr_find
  import prio_enc_pkg::*;
#(
  parameter int unsigned N = 16,
  parameter int unsigned W = clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] lp,
  input  logic         mode,
  output logic [W-1:0] grant,
  output logic         any,
  output logic         multi
);

  logic [2*N-1:0] dbl;
  int unsigned    pos;
  int unsigned    hi;

  always_comb begin
    dbl = '0;
    pos = 0;
    hi  = 0;
    // Lower copy keeps only bits above lp, upper copy is the full vector:
    // the lowest set bit of the concatenation is the first request found
    // scanning lp+1 .. N-1, 0 .. lp.
    for (int unsigned i = 0; i < N; i++) begin
      dbl[i]   = req[i] && (i > int'(lp));
      dbl[N+i] = req[i];
    end
    for (int unsigned i = 2*N; i > 0; i--) begin
      if (dbl[i-1]) pos = i - 1;
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i]) hi = i;
    end
    if (mode == MODE_RR) grant = W'((pos >= N) ? pos - N : pos);
    else                 grant = W'(hi);
  end

  assign any   = |req;
  assign multi = $countones(req) > 1;

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) priority encoder with fixed or round-robin grant
// selection and a single-entry valid/ready output stage.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : prio_encoder_rr_if slave modport (en, mode, req, out_ready in;
//         out_valid, out_idx, out_multi, busy out)
module prio_encoder_rr
  import prio_enc_pkg::*;
#(
  parameter int unsigned N       = 16,
  parameter int unsigned RR_INIT = N - 1
) (
  input  logic               clk,
  input  logic               rst,
  prio_encoder_rr_if.slave   bus
);

  localparam int unsigned W = clog2(N);

  logic [W-1:0] lp_q, lp_d;
  logic [W-1:0] idx_q, idx_d;
  logic         valid_q, valid_d;
  logic         multi_q, multi_d;
  logic [W-1:0] grant;
  logic         any;
  logic         multi;
  logic         cap;

  rr_find #(
    .N (N),
    .W (W)
  ) u_find (
    .req   (bus.req),
    .lp    (lp_q),
    .mode  (bus.mode),
    .grant (grant),
    .any   (any),
    .multi (multi)
  );

  always_comb begin
    cap     = bus.en && any && (!valid_q || bus.out_ready);
    lp_d    = lp_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    multi_d = multi_q;
    if (cap) begin
      valid_d = 1'b1;
      idx_d   = grant;
      multi_d = multi;
      if (bus.mode == MODE_RR) lp_d = grant;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lp_q    <= W'(RR_INIT);
      idx_q   <= '0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      lp_q    <= lp_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_multi = multi_q;
  assign bus.busy      = valid_q && !bus.out_ready;

endmodule

// File: tb/tb_prio_encoder_rr.sv
module tb_prio_encoder_rr;
  import prio_enc_pkg::*;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  // model state: index 0 = N=16 instance, index 1 = N=5 instance
  bit m_valid [2];
  int m_idx   [2];
  bit m_multi [2];
  int m_lp    [2];

  prio_encoder_rr_if #(.N(16)) b16 ();
  prio_encoder_rr_if #(.N(5))  b5  ();

  prio_encoder_rr #(.N(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
  prio_encoder_rr #(.N(5))  dut5  (.clk(clk), .rst(rst), .bus(b5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_grant(input int n, input logic [63:0] r, input bit m, input int lp);
    if (!m) begin
      for (int i = n - 1; i >= 0; i--) if (r[i]) return i;
      return 0;
    end
    for (int k = 1; k <= n; k++) if (r[(lp + k) % n]) return (lp + k) % n;
    return 0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 0;
      m_idx[d]   = 0;
      m_multi[d] = 0;
      m_lp[d]    = (d == 0) ? 15 : 4;
    end
  endtask

  task automatic model_edge(input int d, input int n, input logic [63:0] r,
                            input bit e, input bit m, input bit rdy);
    int g;
    if (e && (r != 0) && (!m_valid[d] || rdy)) begin
      g          = ref_grant(n, r, m, m_lp[d]);
      m_valid[d] = 1;
      m_idx[d]   = g;
      m_multi[d] = $countones(r) > 1;
      if (m) m_lp[d] = g;
    end else if (rdy) begin
      m_valid[d] = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b16.en = 1'b1; b16.req = 16'hFFFF; b16.mode = 1'b0; b16.out_ready = 1'b0;
    cyc();
    n_chk++;
    if (b16.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid_during got %b exp 0", b16.out_valid);
    end
    rst = 1'b0;
    b16.en = 1'b0;
    model_reset();
    cyc();
    n_chk++;
    if (b16.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid_after got %b exp 0", b16.out_valid);
    end
    n_chk++;
    if (b16.out_idx !== 4'd0 || b16.out_multi !== 1'b0) begin
      n_fail++; $display("FAIL reset_idx_multi got %0d/%b exp 0/0", b16.out_idx, b16.out_multi);
    end
  endtask

  task automatic test_onehot();
    logic [15:0] r;
    do_reset();
    b16.mode = 1'b0; b16.en = 1'b1; b16.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      r = 16'd1 << i;
      b16.req = r;
      cyc();
      n_chk++;
      if (b16.out_valid !== 1'b1 || b16.out_idx !== 4'(i) || b16.out_multi !== 1'b0) begin
        n_fail++;
        $display("FAIL onehot i=%0d got v=%b idx=%0d m=%b exp v=1 idx=%0d m=0",
                 i, b16.out_valid, b16.out_idx, b16.out_multi, i);
      end
    end
  endtask

  task automatic test_fixed();
    b16.mode = 1'b0; b16.en = 1'b1; b16.out_ready = 1'b1;
    b16.req = 16'h8421;
    cyc();
    n_chk++;
    if (b16.out_idx !== 4'd15 || b16.out_multi !== 1'b1) begin
      n_fail++; $display("FAIL fixed_8421 got %0d/%b exp 15/1", b16.out_idx, b16.out_multi);
    end
    b16.req = 16'h0006;
    cyc();
    n_chk++;
    if (b16.out_idx !== 4'd2 || b16.out_multi !== 1'b1) begin
      n_fail++; $display("FAIL fixed_0006 got %0d/%b exp 2/1", b16.out_idx, b16.out_multi);
    end
  endtask

  task automatic test_rr_rotation();
    int ea[4];
    int eb[3];
    ea = '{0, 15, 0, 15};
    eb = '{4, 8, 4};
    do_reset();
    b16.mode = 1'b1; b16.en = 1'b1; b16.out_ready = 1'b1;
    b16.req = 16'h8001;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_chk++;
      if (b16.out_valid !== 1'b1 || b16.out_idx !== 4'(ea[i])) begin
        n_fail++; $display("FAIL rr_wrap step=%0d got %0d exp %0d", i, b16.out_idx, ea[i]);
      end
    end
    b16.req = 16'h0110;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_chk++;
      if (b16.out_idx !== 4'(eb[i])) begin
        n_fail++; $display("FAIL rr_rotate step=%0d got %0d exp %0d", i, b16.out_idx, eb[i]);
      end
    end
  endtask

  task automatic test_back_pressure();
    do_reset();
    b16.mode = 1'b0; b16.en = 1'b1; b16.out_ready = 1'b1;
    b16.req = 16'h0008;
    cyc();
    n_chk++;
    if (b16.out_idx !== 4'd3 || b16.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_first got %0d/%b exp 3/1", b16.out_idx, b16.out_valid);
    end
    b16.out_ready = 1'b0;
    b16.req = 16'h0020;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_chk++;
      if (b16.out_idx !== 4'd3 || b16.out_valid !== 1'b1 || b16.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold cyc=%0d got idx=%0d v=%b busy=%b exp 3/1/1",
                 i, b16.out_idx, b16.out_valid, b16.busy);
      end
    end
    b16.out_ready = 1'b1;
    #1;
    n_chk++;
    if (b16.busy !== 1'b0) begin
      n_fail++; $display("FAIL bp_busy_release got %b exp 0", b16.busy);
    end
    cyc();
    n_chk++;
    if (b16.out_idx !== 4'd5 || b16.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_reload got %0d/%b exp 5/1", b16.out_idx, b16.out_valid);
    end
  endtask

  task automatic test_idle();
    do_reset();
    b16.mode = 1'b1; b16.en = 1'b1; b16.out_ready = 1'b1; b16.req = 16'hFFFF;
    cyc();
    cyc();
    n_chk++;
    if (b16.out_idx !== 4'd1) begin
      n_fail++; $display("FAIL idle_pre got %0d exp 1", b16.out_idx);
    end
    b16.en = 1'b0;
    cyc();
    n_chk++;
    if (b16.out_valid !== 1'b0 || b16.out_idx !== 4'd1) begin
      n_fail++; $display("FAIL idle_en0 got v=%b idx=%0d exp 0/1", b16.out_valid, b16.out_idx);
    end
    b16.en = 1'b1; b16.req = 16'h0000;
    cyc();
    n_chk++;
    if (b16.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL idle_req0 got %b exp 0", b16.out_valid);
    end
    b16.req = 16'hFFFF;
    cyc();
    n_chk++;
    if (b16.out_idx !== 4'd2 || b16.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL idle_resume got %0d/%b exp 2/1", b16.out_idx, b16.out_valid);
    end
    b16.out_ready = 1'b0; b16.en = 1'b0;
    cyc();
    b16.en = 1'b1; b16.req = 16'h0000;
    cyc();
    n_chk++;
    if (b16.out_valid !== 1'b1 || b16.out_idx !== 4'd2 || b16.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_stall_hold got v=%b idx=%0d busy=%b exp 1/2/1",
               b16.out_valid, b16.out_idx, b16.busy);
    end
    b16.out_ready = 1'b1; b16.req = 16'hFFFF;
    cyc();
    n_chk++;
    if (b16.out_idx !== 4'd3) begin
      n_fail++; $display("FAIL idle_lp_kept got %0d exp 3", b16.out_idx);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    b16.mode = 1'b1; b16.en = 1'b1; b16.out_ready = 1'b1; b16.req = 16'hFFFF;
    cyc();
    cyc();
    b16.out_ready = 1'b0;
    cyc();
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if (b16.out_valid !== 1'b0 || b16.out_idx !== 4'd0 || b16.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst got v=%b idx=%0d busy=%b exp 0/0/0",
               b16.out_valid, b16.out_idx, b16.busy);
    end
    #1;
    rst = 1'b0;
    model_reset();
    b16.out_ready = 1'b1;
    cyc();
    n_chk++;
    if (b16.out_valid !== 1'b1 || b16.out_idx !== 4'd0) begin
      n_fail++; $display("FAIL async_rst_first got %0d/%b exp 0/1", b16.out_idx, b16.out_valid);
    end
  endtask

  task automatic test_param5();
    int e[3];
    e = '{0, 4, 0};
    do_reset();
    b16.en = 1'b0;
    b5.mode = 1'b1; b5.en = 1'b1; b5.out_ready = 1'b1; b5.req = 5'b10001;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_chk++;
      if (b5.out_valid !== 1'b1 || b5.out_idx !== 3'(e[i]) || b5.out_multi !== 1'b1) begin
        n_fail++;
        $display("FAIL n5_rotate step=%0d got idx=%0d v=%b m=%b exp %0d/1/1",
                 i, b5.out_idx, b5.out_valid, b5.out_multi, e[i]);
      end
    end
    b5.en = 1'b0;
  endtask

  task automatic test_random();
    logic [63:0] r16, r5;
    bit e16, m16, y16, e5, m5, y5;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(3))
        0:       r16 = 64'd0;
        1:       r16 = 64'd1 << $urandom_range(15);
        default: r16 = 64'($urandom_range(16'hFFFF));
      endcase
      case ($urandom_range(3))
        0:       r5 = 64'd0;
        1:       r5 = 64'd1 << $urandom_range(4);
        default: r5 = 64'($urandom_range(31));
      endcase
      e16 = $urandom_range(9) < 8; m16 = $urandom_range(1) == 1; y16 = $urandom_range(9) < 7;
      e5  = $urandom_range(9) < 8; m5  = $urandom_range(1) == 1; y5  = $urandom_range(9) < 7;
      b16.req = r16[15:0]; b16.en = e16; b16.mode = m16; b16.out_ready = y16;
      b5.req  = r5[4:0];   b5.en  = e5;  b5.mode  = m5;  b5.out_ready  = y5;
      model_edge(0, 16, r16, e16, m16, y16);
      model_edge(1, 5, r5, e5, m5, y5);
      cyc();
      n_chk++;
      if (b16.out_valid !== m_valid[0] || b16.out_idx !== 4'(m_idx[0]) ||
          b16.out_multi !== m_multi[0] || b16.busy !== (m_valid[0] && !y16)) begin
        n_fail++;
        $display("FAIL rand16 c=%0d got v=%b idx=%0d m=%b busy=%b exp v=%b idx=%0d m=%b",
                 c, b16.out_valid, b16.out_idx, b16.out_multi, b16.busy,
                 m_valid[0], m_idx[0], m_multi[0]);
      end
      n_chk++;
      if (b5.out_valid !== m_valid[1] || b5.out_idx !== 3'(m_idx[1]) ||
          b5.out_multi !== m_multi[1] || b5.busy !== (m_valid[1] && !y5)) begin
        n_fail++;
        $display("FAIL rand5 c=%0d got v=%b idx=%0d m=%b busy=%b exp v=%b idx=%0d m=%b",
                 c, b5.out_valid, b5.out_idx, b5.out_multi, b5.busy,
                 m_valid[1], m_idx[1], m_multi[1]);
      end
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b0;
    b16.en = 1'b0; b16.mode = 1'b0; b16.req = '0; b16.out_ready = 1'b1;
    b5.en  = 1'b0; b5.mode  = 1'b0; b5.req  = '0; b5.out_ready  = 1'b1;
    model_reset();
    test_reset();
    test_onehot();
    test_fixed();
    test_rr_rotation();
    test_back_pressure();
    test_idle();
    test_async_reset();
    test_param5();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
